ddr_resp_model: RTL
===================

# ddr_resp_model

Synthesizable responder for the Gowin DDR user-command interface, the memory side of the interface driven by `dram_arb`. It accepts read and write commands, stores 128-bit words in an internal block-RAM array, and returns read data in order at a fixed latency. It also models calibration delay and command back-pressure. It stands in for the Gowin DDR controller in simulation and on boards without DDR, so the arbiter and caches are exercised against a deterministic memory.

## Interface
- `LG_WORDS`, 10: log2 of the number of 128-bit words in the array.
- `RD_LAT`, 6: cycles from read-command acceptance to `ddr_rd_data_valid`; legal range 2..16.
- `LG_QDEPTH`, 2: log2 of the maximum number of reads in flight; must satisfy 2**LG_QDEPTH ≤ RD_LAT.
- `CALIB_CYCLES`, 64: cycles after reset before calibration completes; must be ≥1.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ddr_cmd`  in  3  command code: 3'b001 read, 3'b000 write.
- `ddr_cmd_en`  in  1  command valid.
- `ddr_addr`  in  28  byte address.
- `ddr_wr_data`  in  128  write data.
- `ddr_wr_data_mask`  in  16  per-byte mask; 1 = byte not written.
- `ddr_wr_data_en`  in  1  write data valid.
- `ddr_calib_done`  out  1  calibration complete.
- `ddr_cmd_ready`  out  1  command accepted this cycle if `ddr_cmd_en` is high.
- `ddr_rd_data`  out  128  read data.
- `ddr_rd_data_valid`  out  1  read data valid, one cycle per read.
- `err`  out  1  sticky protocol-error flag.

## Operation
- **State machine:** CALIB → IDLE ↔ WDATA.
- **CALIB:**
  - An internal counter counts from 0 after reset.
  - At count CALIB_CYCLES-1 the FSM moves to IDLE, and `ddr_calib_done` goes high and stays high until the next reset.
- **Accept rule:** a command is accepted when `ddr_cmd_en & ddr_cmd_ready`.
- **`ddr_cmd_ready` rule:** `ddr_cmd_ready = (state==IDLE) & (inflight < 2**LG_QDEPTH)`.
- **Address mapping:**
  - Word index = `ddr_addr[LG_WORDS+3:4]`.
  - Bits [3:0] are ignored.
  - Bits above LG_WORDS+3 are ignored, so the array aliases across the full address space.
- **Read:**
  - The array word is sampled at acceptance.
  - The read enters a RD_LAT-deep valid/data shift pipeline.
  - Results are returned in acceptance order, one per cycle, back-to-back.
- **`inflight` counter:**
  - Width LG_QDEPTH+1.
  - +1 on read accept, -1 on `ddr_rd_data_valid`.
  - Unchanged if both happen in the same cycle.
- **Write with data in the command cycle:** if `ddr_wr_data_en` is high in the accept cycle, the unmasked bytes are written that cycle and the FSM stays in IDLE.
- **Write without data:** the latched word index is held, the FSM enters WDATA, and `ddr_cmd_ready` is low. The first cycle with `ddr_wr_data_en` writes the data and returns to IDLE.
- **Read/write ordering:**
  - A read accepted after a write's data cycle observes the written data.
  - No read can be accepted in a WDATA cycle, so read/write simultaneity cannot occur.
- **Error conditions (each sets `err`, which holds until reset):**
  - Accepted command with a code other than 000/001: the command is dropped.
  - `ddr_wr_data_en` high in IDLE with no write accepted that cycle: the data is ignored.
  - `ddr_cmd_en` high during CALIB.
- **Array contents:** not cleared by reset; initial contents are undefined.

## Timing
- **Reset values:** `ddr_calib_done`=0, `ddr_cmd_ready`=0, `ddr_rd_data_valid`=0, `ddr_rd_data`=0, `err`=0, FSM=CALIB, `inflight`=0, pipeline cleared.
- **Calibration:** `ddr_calib_done` and `ddr_cmd_ready` first go high exactly CALIB_CYCLES cycles after the first cycle with `rst_n` high.
- **Read latency:** a read accepted at edge T gives `ddr_rd_data_valid`=1 with data in the cycle after edge T+RD_LAT-1, i.e. exactly RD_LAT cycles later, for one cycle.
- **`ddr_rd_data` between reads:** holds its last value when `ddr_rd_data_valid` is low.
- **Back-pressure:** with 2**LG_QDEPTH reads outstanding, `ddr_cmd_ready` is low. It rises in the cycle after the oldest read's valid cycle.
- **Reset mid-operation:**
  - In-flight reads are discarded.
  - A pending WDATA write is abandoned.
  - `ddr_rd_data_valid` is 0 in the cycle after the reset edge.
  - Calibration restarts.

## Test plan
- **Calibration delay:** assert reset, release, CALIB_CYCLES=64 → `ddr_calib_done` and `ddr_cmd_ready` rise at cycle 64. A `ddr_cmd_en` at cycle 10 sets `err` and nothing is accepted.
- **Write then read:**
  - Write addr 0x0000_0120 with data 128'h00..FF and mask 0 in the command cycle.
  - Read addr 0x0000_012C → valid exactly 6 cycles after the read accept, data 128'h00..FF.
- **Delayed write data and mask:**
  - Write command to word 5, data 3 cycles later with mask 16'hFFFE over a word previously holding all-0xAA.
  - `ddr_cmd_ready` is low for those 3 cycles.
  - A readback of word 5 returns byte0 = new data and bytes 1..15 = 0xAA.
- **Back-pressure and in-order return:**
  - Issue 8 back-to-back reads to words 0..7, each preloaded with its own index.
  - `ddr_cmd_ready` drops after 4 accepts and recovers.
  - Valids return data 0..7 in order, with no gaps during the 4-deep bursts.
- **Aliasing and bad command:**
  - Read addr 0x0400_0050 returns word 5.
  - `ddr_cmd`=3'b010 accepted → `err`=1, no `ddr_rd_data_valid` generated.
- **Reset mid-flight:** reset asserted with 3 reads in flight → no `ddr_rd_data_valid` afterward, and array contents survive (a read after recalibration returns the prior data).

Source files
------------

// File: rtl/ddr_resp_model_if.sv
// DDR user-command bus between a requester (master) and the memory responder (slave).
// Carries command, write data/mask and in-order read return plus calibration and error status.
interface ddr_resp_model_if;
    logic [2:0]   ddr_cmd;
    logic         ddr_cmd_en;
    logic [27:0]  ddr_addr;
    logic [127:0] ddr_wr_data;
    logic [15:0]  ddr_wr_data_mask;
    logic         ddr_wr_data_en;
    logic         ddr_calib_done;
    logic         ddr_cmd_ready;
    logic [127:0] ddr_rd_data;
    logic         ddr_rd_data_valid;
    logic         err;

    modport master (
        output ddr_cmd, ddr_cmd_en, ddr_addr, ddr_wr_data, ddr_wr_data_mask, ddr_wr_data_en,
        input  ddr_calib_done, ddr_cmd_ready, ddr_rd_data, ddr_rd_data_valid, err
    );

    modport slave (
        input  ddr_cmd, ddr_cmd_en, ddr_addr, ddr_wr_data, ddr_wr_data_mask, ddr_wr_data_en,
        output ddr_calib_done, ddr_cmd_ready, ddr_rd_data, ddr_rd_data_valid, err
    );
endinterface

// File: rtl/ddr_resp_model.sv
// Deterministic stand-in for the Gowin DDR controller: block-RAM array, calibration delay, in-order reads.
// Reads return RD_LAT cycles after accept; ready drops while calibrating, awaiting write data or with 2**LG_QDEPTH reads in flight.
module ddr_resp_model #(
    parameter int LG_WORDS     = 10,
    parameter int RD_LAT       = 6,
    parameter int LG_QDEPTH    = 2,
    parameter int CALIB_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    ddr_resp_model_if.slave s_ddr
);
    localparam int QDEPTH = 1 << LG_QDEPTH;
    localparam int CAL_W  = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
    localparam logic [CAL_W-1:0]     CAL_LAST = CAL_W'(CALIB_CYCLES - 1);
    localparam logic [LG_QDEPTH:0]   QFULL    = (LG_QDEPTH + 1)'(QDEPTH);
    localparam logic [2:0]           CMD_WR   = 3'b000;
    localparam logic [2:0]           CMD_RD   = 3'b001;

    typedef enum logic [1:0] {
        ST_CALIB = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WDATA = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CAL_W-1:0]      r_cal_cnt;
    logic [LG_QDEPTH:0]    r_inflight;
    logic [LG_WORDS-1:0]   r_wr_idx;
    logic [LG_WORDS-1:0]   w_cmd_idx;
    logic [LG_WORDS-1:0]   w_wr_idx;
    logic                  w_cmd_ready;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_mem_we;
    logic                  w_wdat_latch;
    logic                  w_err_set;
    logic                  r_err;
    logic                  w_rd_out_vld;
    logic                  w_unused_addr;

    logic [127:0]          r_mem [1 << LG_WORDS];
    logic [127:0]          r_rd_word;
    logic [RD_LAT-1:0]     r_pipe_vld;
    logic [127:0]          r_pipe_dat [1:RD_LAT-1];

    // Byte offset and high address bits are dropped, so the array aliases across the address space.
    assign w_cmd_idx     = s_ddr.ddr_addr[LG_WORDS+3:4];
    assign w_unused_addr = ^{s_ddr.ddr_addr[27:LG_WORDS+4], s_ddr.ddr_addr[3:0]};
    assign w_rd_out_vld  = r_pipe_vld[RD_LAT-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_CALIB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cmd_ready  = 1'b0;
        w_rd_acc     = 1'b0;
        w_wr_acc     = 1'b0;
        w_mem_we     = 1'b0;
        w_wdat_latch = 1'b0;
        w_err_set    = 1'b0;
        w_wr_idx     = w_cmd_idx;
        case (r_state)
            ST_CALIB: begin
                if (r_cal_cnt == CAL_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
                if (s_ddr.ddr_cmd_en) begin
                    w_err_set = 1'b1;
                end
            end
            ST_IDLE: begin
                w_cmd_ready = (r_inflight < QFULL);
                if (s_ddr.ddr_cmd_en && w_cmd_ready) begin
                    case (s_ddr.ddr_cmd)
                        CMD_RD: w_rd_acc = 1'b1;
                        CMD_WR: begin
                            w_wr_acc = 1'b1;
                            if (s_ddr.ddr_wr_data_en) begin
                                w_mem_we = 1'b1;
                            end else begin
                                w_wdat_latch = 1'b1;
                                w_state_nxt  = ST_WDATA;
                            end
                        end
                        default: w_err_set = 1'b1;
                    endcase
                end
                if (s_ddr.ddr_wr_data_en && !w_wr_acc) begin
                    w_err_set = 1'b1;
                end
            end
            ST_WDATA: begin
                w_wr_idx = r_wr_idx;
                if (s_ddr.ddr_wr_data_en) begin
                    w_mem_we    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_CALIB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cal_cnt <= '0;
        end else if (r_state == ST_CALIB && r_cal_cnt != CAL_LAST) begin
            r_cal_cnt <= r_cal_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wdat_latch) begin
            r_wr_idx <= w_cmd_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            case ({w_rd_acc, w_rd_out_vld})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Array is deliberately outside reset so contents survive a re-calibration.
    always_ff @(posedge clk) begin
        if (w_mem_we && rst_n) begin
            for (int b = 0; b < 16; b++) begin
                if (!s_ddr.ddr_wr_data_mask[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= s_ddr.ddr_wr_data[8*b +: 8];
                end
            end
        end
        if (w_rd_acc && rst_n) begin
            r_rd_word <= r_mem[w_cmd_idx];
        end
    end

    // Data stages only load behind a valid, so the output holds its last read between returns.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_dat[i] <= '0;
            end
        end else begin
            r_pipe_vld <= {r_pipe_vld[RD_LAT-2:0], w_rd_acc};
            if (r_pipe_vld[0]) begin
                r_pipe_dat[1] <= r_rd_word;
            end
            for (int i = 2; i < RD_LAT; i++) begin
                if (r_pipe_vld[i-1]) begin
                    r_pipe_dat[i] <= r_pipe_dat[i-1];
                end
            end
        end
    end

    assign s_ddr.ddr_calib_done    = (r_state != ST_CALIB);
    assign s_ddr.ddr_cmd_ready     = w_cmd_ready;
    assign s_ddr.ddr_rd_data       = r_pipe_dat[RD_LAT-1];
    assign s_ddr.ddr_rd_data_valid = w_rd_out_vld;
    assign s_ddr.err               = r_err;
endmodule
